// File: rtl/ipf_tile_sequencer_pkg.sv
// Shared IPF codes: output control words, kernel size encodings and the
// per-kernel lead/round derivations used by the tile sequencer and the IPF array.
package ipf_tile_sequencer_pkg;

    localparam logic [1:0] CTRL_END   = 2'd0;
    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_HOLD  = 2'd2;

    localparam logic [1:0] WSIZE_3   = 2'd0;
    localparam logic [1:0] WSIZE_5   = 2'd1;
    localparam logic [1:0] WSIZE_7   = 2'd2;
    localparam logic [1:0] WSIZE_BAD = 2'd3;

    // Words of each pass that prime the IPF line window before results are valid.
    function automatic logic [2:0] lead_of(input logic [1:0] wsize);
        case (wsize)
            WSIZE_5: lead_of = 3'd4;
            WSIZE_7: lead_of = 3'd6;
            default: lead_of = 3'd2;
        endcase
    endfunction

    function automatic logic [2:0] rounds_of(input logic [1:0] wsize);
        case (wsize)
            WSIZE_5: rounds_of = 3'd2;
            WSIZE_7: rounds_of = 3'd4;
            default: rounds_of = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/ipf_tile_sequencer_if.sv
// Input stream (upstream -> sequencer) and output stream (sequencer -> IPF).
interface ipf_tile_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int GRP_W  = 4
) ();
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_ctrl;
    logic [2:0]        o_wround;
    logic [GRP_W-1:0]  o_wgroup;

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_ctrl, o_wround, o_wgroup
    );

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_ctrl, o_wround, o_wgroup
    );
endinterface

// File: rtl/ipf_tile_sequencer_buf.sv
// Tile buffer: TILE x DATA_W register file, one synchronous write port and
// one registered read port. Read data holds until the next read enable.
module ipf_tile_buf #(
    parameter int DATA_W = 64,
    parameter int TILE   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(TILE)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    re,
    input  logic [$clog2(TILE)-1:0] raddr,
    output logic [DATA_W-1:0]       rdata
);
    logic [DATA_W-1:0] mem [TILE];

    // Contents are don't-care after reset, so the array itself is not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ipf_tile_sequencer.sv
// IPF front-end: captures one tile while forwarding it as pass 0, then replays
// it for every remaining kernel round / weight group, drains and ends the job.
module ipf_tile_sequencer
    import ipf_tile_sequencer_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int TILE      = 8,
    parameter int GRP_W     = 4,
    parameter int DRAIN_CYC = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic [1:0]          cfg_wsize,
    input  logic                cfg_stride,
    input  logic [GRP_W-1:0]    cfg_ngroups,
    ipf_tile_sequencer_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);
    localparam int AW = $clog2(TILE);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FILL, ST_REPLAY, ST_DRAIN, ST_FIN
    } state_e;

    state_e state, state_nxt;

    logic [1:0]       wsize_q;
    logic             stride_q;
    logic [GRP_W-1:0] ng_last_q;
    logic [AW-1:0]    wcnt;
    logic [1:0]       round_q;
    logic [GRP_W-1:0] grp_q;
    logic [DW-1:0]    dcnt;

    logic              o_valid_q;
    logic              o_src_buf;
    logic [DATA_W-1:0] o_data_q;
    logic [1:0]        o_ctrl_q;
    logic [2:0]        o_wround_q;
    logic [GRP_W-1:0]  o_wgroup_q;
    logic [DATA_W-1:0] buf_rdata;

    logic             adv, i_ready_c, buf_we, buf_re, word_step;
    logic             word_last, pass_last, drain_last, is_hold;
    logic [2:0]       lead, rounds;
    logic [1:0]       rounds_last;
    logic [GRP_W-1:0] wg_word;

    assign adv         = ~o_valid_q | bus.o_ready;
    assign lead        = lead_of(wsize_q);
    assign rounds      = rounds_of(wsize_q);
    assign rounds_last = 2'(rounds - 3'd1);
    assign word_last   = (wcnt == AW'(TILE - 1));
    assign pass_last   = (round_q == rounds_last) && (grp_q == ng_last_q);
    assign drain_last  = (dcnt == DW'(DRAIN_CYC - 1));
    assign is_hold     = (wcnt < AW'(lead));

    // Stride 2 interleaves even/odd weight sets: the group LSB becomes a START
    // toggle. LEAD is always even, so the toggle equals the word index LSB.
    always_comb begin
        wg_word = grp_q;
        if (stride_q)
            wg_word = {grp_q[GRP_W-1:1], is_hold ? o_wgroup_q[0] : wcnt[0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        i_ready_c = 1'b0;
        buf_we    = 1'b0;
        buf_re    = 1'b0;
        word_step = 1'b0;
        case (state)
            ST_IDLE: if (cmd_start) state_nxt = ST_FILL;
            ST_FILL: begin
                i_ready_c = adv;
                if (adv && bus.i_valid) begin
                    buf_we    = 1'b1;
                    word_step = 1'b1;
                    if (word_last) state_nxt = pass_last ? ST_DRAIN : ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                if (adv) begin
                    buf_re    = 1'b1;
                    word_step = 1'b1;
                    if (word_last && pass_last) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (adv && drain_last) state_nxt = ST_FIN;
            ST_FIN:   if (adv) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Job configuration and word / pass / drain counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wsize_q   <= WSIZE_3;
            stride_q  <= 1'b0;
            ng_last_q <= '0;
            wcnt      <= '0;
            round_q   <= '0;
            grp_q     <= '0;
            dcnt      <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (state == ST_IDLE && cmd_start) begin
                wsize_q   <= (cfg_wsize == WSIZE_BAD) ? WSIZE_3 : cfg_wsize;
                stride_q  <= cfg_stride;
                ng_last_q <= (cfg_ngroups == '0) ? '0 : cfg_ngroups - 1'b1;
                cfg_err   <= (cfg_wsize == WSIZE_BAD);
                wcnt      <= '0;
                round_q   <= '0;
                grp_q     <= '0;
                dcnt      <= '0;
            end else begin
                if (word_step) begin
                    wcnt <= wcnt + 1'b1;
                    if (word_last) begin
                        if (round_q == rounds_last) begin
                            round_q <= '0;
                            grp_q   <= grp_q + 1'b1;
                        end else begin
                            round_q <= round_q + 1'b1;
                        end
                    end
                end
                if (state == ST_DRAIN && adv) dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Output stage. Replay words come straight from the buffer read register,
    // which only reloads on adv, so o_data stays frozen under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid_q  <= 1'b0;
            o_src_buf  <= 1'b0;
            o_data_q   <= '0;
            o_ctrl_q   <= CTRL_END;
            o_wround_q <= '0;
            o_wgroup_q <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (adv) begin
                o_valid_q <= 1'b0;
                o_src_buf <= 1'b0;
                if (word_step) begin
                    o_valid_q  <= 1'b1;
                    o_src_buf  <= (state == ST_REPLAY);
                    o_wgroup_q <= wg_word;
                    if (state == ST_FILL) o_data_q <= bus.i_data;
                    if (is_hold) begin
                        o_ctrl_q <= CTRL_HOLD;
                    end else begin
                        o_ctrl_q   <= CTRL_START;
                        o_wround_q <= {1'b0, round_q};
                    end
                end else if (state == ST_DRAIN) begin
                    o_valid_q <= 1'b1;
                    o_data_q  <= '0;
                    o_ctrl_q  <= CTRL_HOLD;
                end else if (state == ST_FIN) begin
                    o_valid_q <= 1'b1;
                    o_data_q  <= '0;
                    o_ctrl_q  <= CTRL_END;
                    done      <= 1'b1;
                end
            end
        end
    end

    ipf_tile_buf #(.DATA_W(DATA_W), .TILE(TILE)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr (wcnt),
        .wdata (bus.i_data),
        .re    (buf_re),
        .raddr (wcnt),
        .rdata (buf_rdata)
    );

    assign bus.i_ready  = i_ready_c;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_data   = o_src_buf ? buf_rdata : o_data_q;
    assign bus.o_ctrl   = o_ctrl_q;
    assign bus.o_wround = o_wround_q;
    assign bus.o_wgroup = o_wgroup_q;
    assign busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_ipf_tile_sequencer.sv
// Randomised directed bench for ipf_tile_sequencer: each job is predicted as a
// flat word list from the kernel/group rules and compared on every output handshake.
module tb_ipf_tile_sequencer;
    import ipf_tile_sequencer_pkg::*;

    localparam int DATA_W    = 64;
    localparam int TILE      = 8;
    localparam int GRP_W     = 4;
    localparam int DRAIN_CYC = 10;

    typedef struct packed {
        logic [1:0]        ctrl;
        logic [DATA_W-1:0] data;
        logic [2:0]        wr;
        logic [GRP_W-1:0]  wg;
    } word_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_start = 1'b0;
    logic [1:0]       cfg_wsize = 2'd0;
    logic             cfg_stride = 1'b0;
    logic [GRP_W-1:0] cfg_ngroups = '0;
    logic             busy, done, cfg_err;
    int               errors = 0;
    int               checks = 0;
    int               nout;

    ipf_tile_sequencer_if #(.DATA_W(DATA_W), .GRP_W(GRP_W)) bus ();

    ipf_tile_sequencer #(
        .DATA_W(DATA_W), .TILE(TILE), .GRP_W(GRP_W), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cfg_wsize   (cfg_wsize),
        .cfg_stride  (cfg_stride),
        .cfg_ngroups (cfg_ngroups),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [1:0] ws, input logic st, input logic [GRP_W-1:0] ng,
                       input bit bp, input bit poke, input int rst_at, output int n);
        word_t             exp_q[$];
        word_t             w, got;
        logic [DATA_W-1:0] tile [TILE];
        int eff, lead, rounds, ngv, t, in_idx, done_cnt, extra_in, exp_total;
        bit done_ok, ended, first, poked, poke_chk;

        eff    = (ws == 2'd3) ? 0 : int'(ws);
        lead   = 2 + 2 * eff;
        rounds = 1 << eff;
        ngv    = (ng == '0) ? 1 : int'(ng);
        for (int i = 0; i < TILE; i++) tile[i] = {$urandom, $urandom};
        for (int p = 0; p < ngv * rounds; p++) begin
            t = 0;
            for (int i = 0; i < TILE; i++) begin
                w.data = tile[i];
                w.wr   = 3'(p % rounds);
                w.wg   = GRP_W'(p / rounds);
                if (i < lead) begin
                    w.ctrl = CTRL_HOLD;
                end else begin
                    w.ctrl = CTRL_START;
                    if (st) w.wg = (w.wg & ~GRP_W'(1)) | GRP_W'(t);
                    t ^= 1;
                end
                exp_q.push_back(w);
            end
        end
        w.data = '0; w.wr = '0; w.wg = '0;
        w.ctrl = CTRL_HOLD;
        for (int i = 0; i < DRAIN_CYC; i++) exp_q.push_back(w);
        w.ctrl = CTRL_END;
        exp_q.push_back(w);
        exp_total = exp_q.size();

        in_idx = 0; n = 0; done_cnt = 0; extra_in = 0;
        done_ok = 0; ended = 0; first = 1; poked = 0; poke_chk = 0;

        @(negedge clk);
        cfg_wsize = ws; cfg_stride = st; cfg_ngroups = ng; cmd_start = 1'b1;
        bus.i_valid = 1'b0; bus.o_ready = 1'b1;

        for (int c = 0; c < 4000 && !ended; c++) begin
            @(negedge clk);
            if (first) begin
                cmd_start = 1'b0;
                chk("cfg_err_at_start", 64'(cfg_err), 64'(ws == 2'd3));
                chk("busy_after_start", 64'(busy), 64'(1));
                first = 0;
            end
            if (poke_chk) begin
                cmd_start = 1'b0; cfg_wsize = ws;
                chk("cfg_err_while_busy", 64'(cfg_err), 64'(0));
                poke_chk = 0;
            end
            bus.o_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_idx < TILE) begin
                bus.i_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.i_data  = tile[in_idx];
            end else begin
                bus.i_valid = 1'b1;
                bus.i_data  = {$urandom, $urandom};
            end
            #1;
            if (done) begin
                done_cnt++;
                if (bus.o_valid && bus.o_ctrl == CTRL_END) done_ok = 1;
            end
            if (bus.i_valid && bus.i_ready) begin
                if (in_idx < TILE) in_idx++;
                else extra_in++;
            end
            if (bus.o_valid && bus.o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output_word", 64'(n + 1), 64'(exp_total));
                end else begin
                    got = exp_q.pop_front();
                    chk("o_ctrl", 64'(bus.o_ctrl), 64'(got.ctrl));
                    chk("o_data", bus.o_data, got.data);
                    if (got.ctrl == CTRL_START) begin
                        chk("o_wround", 64'(bus.o_wround), 64'(got.wr));
                        chk("o_wgroup", 64'(bus.o_wgroup), 64'(got.wg));
                    end
                    if (got.ctrl == CTRL_END) ended = 1;
                end
                n++;
            end
            if (poke && !poked && n == 12) begin
                cmd_start = 1'b1; cfg_wsize = 2'd3; poked = 1; poke_chk = 1;
            end
            if (rst_at > 0 && n == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_mid_o_valid", 64'(bus.o_valid), 64'(0));
                chk("rst_mid_busy", 64'(busy), 64'(0));
                @(posedge clk); #1;
                chk("rst_edge_o_valid", 64'(bus.o_valid), 64'(0));
                chk("rst_edge_done", 64'(done), 64'(0));
                @(negedge clk);
                rst = 1'b1;
                bus.i_valid = 1'b0;
                return;
            end
        end
        bus.i_valid = 1'b0;
        chk("end_word_seen", 64'(ended), 64'(1));
        chk("word_count", 64'(n), 64'(exp_total));
        chk("done_pulses", 64'(done_cnt), 64'(1));
        chk("done_with_end", 64'(done_ok), 64'(1));
        chk("input_ignored", 64'(extra_in), 64'(0));
        @(negedge clk);
        chk("idle_o_valid", 64'(bus.o_valid), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.o_ready = 1'b0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_o_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_o_ctrl", 64'(bus.o_ctrl), 64'(CTRL_END));
        chk("rst_o_data", bus.o_data, 64'(0));
        chk("rst_o_wround", 64'(bus.o_wround), 64'(0));
        chk("rst_o_wgroup", 64'(bus.o_wgroup), 64'(0));
        chk("rst_i_ready", 64'(bus.i_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        rst = 1'b1;

        // 3x3 stride1, two groups: 16 words + drain + END
        run(2'd0, 1'b0, 4'd2, 1'b0, 1'b0, 0, nout);
        chk("t1_total_outputs", 64'(nout), 64'(27));
        // 7x7 stride1 and 5x5 stride2, one group
        run(2'd2, 1'b0, 4'd1, 1'b0, 1'b0, 0, nout);
        run(2'd1, 1'b1, 4'd1, 1'b0, 1'b0, 0, nout);
        // random backpressure in every mode, including ngroups=0
        run(2'd0, 1'b0, 4'd2, 1'b1, 1'b0, 0, nout);
        run(2'd1, 1'b1, 4'd3, 1'b1, 1'b0, 0, nout);
        run(2'd2, 1'b1, 4'd0, 1'b1, 1'b0, 0, nout);
        run(2'd2, 1'b0, 4'd5, 1'b1, 1'b0, 0, nout);
        // illegal size runs as 3x3; cmd_start during replay is ignored
        run(2'd3, 1'b0, 4'd1, 1'b0, 1'b0, 0, nout);
        run(2'd2, 1'b0, 4'd1, 1'b0, 1'b1, 0, nout);
        // reset in the middle of a replay pass, then a clean job
        run(2'd1, 1'b0, 4'd2, 1'b0, 1'b0, 12, nout);
        run(2'd0, 1'b1, 4'd2, 1'b0, 1'b0, 0, nout);
        for (int k = 0; k < 4; k++)
            run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                GRP_W'($urandom_range(0, 15)), 1'b1, 1'b0, 0, nout);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
